// File: rtl/vram_framebuffer_if.sv
// rtl/vram_framebuffer_if.sv - scan read, host write and fill control bundle for vram_framebuffer
interface vram_framebuffer_if #(
  parameter int CHANNELS = 3,
  parameter int BPP      = 1,
  parameter int H_PIX    = 128,
  parameter int V_PIX    = 96
);
  localparam int DW = CHANNELS * BPP;
  localparam int XW = $clog2(H_PIX);
  localparam int YW = $clog2(V_PIX);

  logic          rd_en;
  logic [XW-1:0] rd_x;
  logic [YW-1:0] rd_y;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          wr_valid;
  logic          wr_ready;
  logic [XW-1:0] wr_x;
  logic [YW-1:0] wr_y;
  logic [DW-1:0] wr_data;
  logic          fill_start;
  logic [DW-1:0] fill_color;
  logic          busy;
  logic          err_oor;

  modport master (
    output rd_en, rd_x, rd_y, wr_valid, wr_x, wr_y, wr_data, fill_start, fill_color,
    input  rd_data, rd_valid, wr_ready, busy, err_oor
  );

  modport slave (
    input  rd_en, rd_x, rd_y, wr_valid, wr_x, wr_y, wr_data, fill_start, fill_color,
    output rd_data, rd_valid, wr_ready, busy, err_oor
  );
endinterface

// File: rtl/vram_framebuffer.sv
// rtl/vram_framebuffer.sv - single-port pixel framebuffer with scan read, host write and screen fill
module vram_framebuffer #(
  parameter int CHANNELS = 3,
  parameter int BPP      = 1,
  parameter int H_PIX    = 128,
  parameter int V_PIX    = 96
) (
  input logic               clk,
  input logic               rst,
  vram_framebuffer_if.slave bus
);
  localparam int DW    = CHANNELS * BPP;
  localparam int AW    = $clog2(H_PIX * V_PIX);
  localparam int DEPTH = H_PIX * V_PIX;

  typedef enum logic {IDLE, FILL} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] fill_cnt;
  logic [DW-1:0] fill_color_q;
  logic [DW-1:0] mem [0:DEPTH-1];
  logic [DW-1:0] mem_q;
  logic [DW-1:0] rd_hold;
  logic          rd_valid_q;
  logic          rd_oor_q;
  logic          err_q;

  logic          rd_inr, wr_inr, wr_fire, fill_we, mem_we, mem_re;
  logic [AW-1:0] rd_addr, wr_addr, mem_addr;
  logic [DW-1:0] mem_wdata;

  // Address decode, range checks and the single memory port arbiter (read > fill > host)
  always_comb begin
    rd_inr    = (int'(bus.rd_x) < H_PIX) && (int'(bus.rd_y) < V_PIX);
    wr_inr    = (int'(bus.wr_x) < H_PIX) && (int'(bus.wr_y) < V_PIX);
    rd_addr   = AW'(int'(bus.rd_y) * H_PIX + int'(bus.rd_x));
    wr_addr   = AW'(int'(bus.wr_y) * H_PIX + int'(bus.wr_x));
    wr_fire   = bus.wr_valid && bus.wr_ready;
    mem_re    = bus.rd_en && rd_inr;
    mem_we    = fill_we || (wr_fire && wr_inr);
    mem_addr  = wr_addr;
    mem_wdata = bus.wr_data;
    if (bus.rd_en) begin
      mem_addr = rd_addr;
    end else if (fill_we) begin
      mem_addr  = fill_cnt;
      mem_wdata = fill_color_q;
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // FSM next state: fill ends once the last address has been written
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.fill_start) state_nxt = FILL;
      FILL: if (!bus.rd_en && fill_cnt == AW'(DEPTH - 1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: scan reads stall the fill and block the host writer
  always_comb begin
    bus.busy     = (state == FILL);
    fill_we      = (state == FILL) && !bus.rd_en;
    bus.wr_ready = !bus.rd_en && (state == IDLE);
  end

  // Fill address counter and latched fill colour
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_cnt     <= '0;
      fill_color_q <= '0;
    end else if (state == IDLE && bus.fill_start) begin
      fill_cnt     <= '0;
      fill_color_q <= bus.fill_color;
    end else if (fill_we) begin
      fill_cnt <= fill_cnt + 1'b1;
    end
  end

  // Pixel memory: no reset so contents survive rst and map onto block RAM
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_q <= mem[mem_addr];
  end

  // Read qualifier, out-of-range marker and last-value hold register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
      rd_oor_q   <= 1'b0;
      rd_hold    <= '0;
    end else begin
      rd_valid_q <= bus.rd_en;
      rd_oor_q   <= bus.rd_en && !rd_inr;
      if (rd_valid_q) rd_hold <= bus.rd_data;
    end
  end

  // Sticky flag for accepted host writes that fall outside the screen
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_q | (wr_fire && !wr_inr);
  end

  // Read data presentation: zero for off-screen reads, held value between reads
  always_comb begin
    bus.rd_valid = rd_valid_q;
    bus.err_oor  = err_q;
    if (rd_valid_q) bus.rd_data = rd_oor_q ? '0 : mem_q;
    else            bus.rd_data = rd_hold;
  end
endmodule

// File: tb/tb_vram_framebuffer.sv
// tb/tb_vram_framebuffer.sv - self-checking bench for vram_framebuffer
module tb_vram_framebuffer;
  localparam int H = 128;
  localparam int V = 96;
  localparam int DEPTH = H * V;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   fails = 0;
  logic [2:0] model [0:DEPTH-1];

  always #5 clk = ~clk;

  vram_framebuffer_if #(.CHANNELS(3), .BPP(1), .H_PIX(H), .V_PIX(V)) bus ();

  vram_framebuffer #(.CHANNELS(3), .BPP(1), .H_PIX(H), .V_PIX(V)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.rd_en = 0; bus.rd_x = '0; bus.rd_y = '0;
    bus.wr_valid = 0; bus.wr_x = '0; bus.wr_y = '0; bus.wr_data = '0;
    bus.fill_start = 0; bus.fill_color = '0;
  endtask

  task automatic do_read(input int x, input int y, output logic [2:0] d, output logic v);
    bus.rd_en = 1; bus.rd_x = 7'(x); bus.rd_y = 7'(y);
    tick();
    d = bus.rd_data; v = bus.rd_valid;
    bus.rd_en = 0;
  endtask

  task automatic test_reset();
    rst = 1; idle_inputs();
    repeat (3) tick();
    checks++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    checks++; if (bus.rd_valid !== 1'b0) begin fails++; $display("FAIL reset_rd_valid: got %b want 0", bus.rd_valid); end
    checks++; if (bus.rd_data !== 3'd0) begin fails++; $display("FAIL reset_rd_data: got %0d want 0", bus.rd_data); end
    checks++; if (bus.err_oor !== 1'b0) begin fails++; $display("FAIL reset_err_oor: got %b want 0", bus.err_oor); end
    rst = 0;
    tick();
    checks++; if (bus.wr_ready !== 1'b1) begin fails++; $display("FAIL reset_wr_ready: got %b want 1", bus.wr_ready); end
    bus.rd_en = 1; #1;
    checks++; if (bus.wr_ready !== 1'b0) begin fails++; $display("FAIL ready_blocked_by_read: got %b want 0", bus.wr_ready); end
    bus.rd_en = 0; #1;
  endtask

  task automatic test_write_read();
    logic [2:0] d; logic v;
    bus.wr_valid = 1; bus.wr_x = 7'd5; bus.wr_y = 7'd2; bus.wr_data = 3'b101; #1;
    checks++; if (bus.wr_ready !== 1'b1) begin fails++; $display("FAIL wr_ready_idle: got %b want 1", bus.wr_ready); end
    tick();
    bus.wr_valid = 0;
    do_read(5, 2, d, v);
    checks++; if (v !== 1'b1) begin fails++; $display("FAIL wr_rd_valid: got %b want 1", v); end
    checks++; if (d !== 3'b101) begin fails++; $display("FAIL wr_rd_data: got %0d want 5", d); end
    checks++; if (dut.mem[261] !== 3'b101) begin fails++; $display("FAIL mem_261: got %0d want 5", dut.mem[261]); end
    tick();
    checks++; if (bus.rd_valid !== 1'b0) begin fails++; $display("FAIL rd_valid_drop: got %b want 0", bus.rd_valid); end
    checks++; if (bus.rd_data !== 3'b101) begin fails++; $display("FAIL rd_data_hold: got %0d want 5", bus.rd_data); end
  endtask

  task automatic test_fill();
    int n; logic [2:0] d; logic v;
    bus.fill_color = 3'b010; bus.fill_start = 1;
    tick();
    bus.fill_start = 0;
    n = 0;
    while (bus.busy && n < 20000) begin n++; tick(); end
    checks++; if (n != DEPTH) begin fails++; $display("FAIL fill_busy_len: got %0d want %0d", n, DEPTH); end
    for (int i = 0; i < DEPTH; i++) model[i] = 3'b010;
    do_read(0, 0, d, v);
    checks++; if (d !== 3'b010 || v !== 1'b1) begin fails++; $display("FAIL fill_read_0_0: got %0d/%b want 2/1", d, v); end
    do_read(127, 95, d, v);
    checks++; if (d !== 3'b010 || v !== 1'b1) begin fails++; $display("FAIL fill_read_127_95: got %0d/%b want 2/1", d, v); end
  endtask

  task automatic test_fill_stall();
    int cycles, reads, w, bad_v, bad_d, a;
    logic r;
    logic [2:0] exp;
    bus.fill_color = 3'd5; bus.fill_start = 1;
    tick();
    bus.fill_start = 0;
    cycles = 0; reads = 0; w = 0; bad_v = 0; bad_d = 0;
    while (bus.busy && cycles < 40000) begin
      r = 1'($urandom_range(0, 1));
      a = $urandom_range(0, DEPTH - 1);
      bus.rd_en = r; bus.rd_x = 7'(a % H); bus.rd_y = 7'(a / H);
      tick();
      cycles++;
      exp = (a < w) ? 3'd5 : model[a];
      if (bus.rd_valid !== r) bad_v++;
      if (r && bus.rd_data !== exp) bad_d++;
      if (r) reads++; else w++;
    end
    bus.rd_en = 0;
    checks++; if (cycles != DEPTH + reads) begin fails++; $display("FAIL stall_busy_len: got %0d want %0d", cycles, DEPTH + reads); end
    checks++; if (bad_v != 0) begin fails++; $display("FAIL stall_rd_valid: got %0d bad pulses want 0", bad_v); end
    checks++; if (bad_d != 0) begin fails++; $display("FAIL stall_rd_data: got %0d bad reads want 0", bad_d); end
    for (int i = 0; i < DEPTH; i++) model[i] = 3'd5;
    tick();
  endtask

  task automatic test_oor();
    logic [2:0] d; logic v;
    bus.wr_valid = 1; bus.wr_x = 7'd0; bus.wr_y = 7'd96; bus.wr_data = 3'd7; #1;
    checks++; if (bus.wr_ready !== 1'b1) begin fails++; $display("FAIL oor_accepted: got %b want 1", bus.wr_ready); end
    tick();
    checks++; if (bus.err_oor !== 1'b1) begin fails++; $display("FAIL oor_err_set: got %b want 1", bus.err_oor); end
    bus.wr_x = 7'd127; bus.wr_y = 7'd127; bus.wr_data = 3'd3;
    tick();
    bus.wr_valid = 0;
    do_read(0, 0, d, v);
    checks++; if (d !== model[0]) begin fails++; $display("FAIL oor_mem_0: got %0d want %0d", d, model[0]); end
    do_read(0, 95, d, v);
    checks++; if (d !== model[95*H]) begin fails++; $display("FAIL oor_mem_row95: got %0d want %0d", d, model[95*H]); end
    do_read(3, 100, d, v);
    checks++; if (d !== 3'd0 || v !== 1'b1) begin fails++; $display("FAIL oor_read: got %0d/%b want 0/1", d, v); end
    repeat (5) tick();
    checks++; if (bus.err_oor !== 1'b1) begin fails++; $display("FAIL oor_err_sticky: got %b want 1", bus.err_oor); end
  endtask

  task automatic test_back_to_back();
    logic [2:0] d, nv; logic v;
    int a;
    a = 20 * H + 10;
    nv = model[a] ^ 3'b111;
    bus.wr_valid = 1; bus.wr_x = 7'd10; bus.wr_y = 7'd20; bus.wr_data = nv;
    for (int k = 0; k < 3; k++) begin
      bus.rd_en = 1; bus.rd_x = 7'd1; bus.rd_y = 7'd1; #1;
      checks++; if (bus.wr_ready !== 1'b0) begin fails++; $display("FAIL bp_ready_%0d: got %b want 0", k, bus.wr_ready); end
      tick();
      checks++; if (bus.rd_data !== model[H+1] || bus.rd_valid !== 1'b1) begin fails++; $display("FAIL bp_read_%0d: got %0d/%b want %0d/1", k, bus.rd_data, bus.rd_valid, model[H+1]); end
    end
    checks++; if (dut.mem[a] !== model[a]) begin fails++; $display("FAIL bp_no_write: got %0d want %0d", dut.mem[a], model[a]); end
    bus.rd_en = 0; #1;
    checks++; if (bus.wr_ready !== 1'b1) begin fails++; $display("FAIL bp_ready_release: got %b want 1", bus.wr_ready); end
    tick();
    bus.wr_valid = 0;
    model[a] = nv;
    do_read(10, 20, d, v);
    checks++; if (d !== nv) begin fails++; $display("FAIL bp_write_done: got %0d want %0d", d, nv); end
  endtask

  task automatic test_random();
    int bad, ra, wa;
    logic r, w;
    logic [2:0] wd, exp;
    bad = 0;
    for (int i = 0; i < 3000; i++) begin
      r = 1'($urandom_range(0, 1)); w = 1'($urandom_range(0, 1));
      ra = $urandom_range(0, 255); wa = $urandom_range(0, 255);
      wd = 3'($urandom);
      bus.rd_en = r; bus.rd_x = 7'(ra % H); bus.rd_y = 7'(ra / H);
      bus.wr_valid = w; bus.wr_x = 7'(wa % H); bus.wr_y = 7'(wa / H); bus.wr_data = wd;
      exp = model[ra];
      tick();
      if (bus.rd_valid !== r) bad++;
      if (r && bus.rd_data !== exp) bad++;
      if (!r && w) model[wa] = wd;
    end
    idle_inputs();
    tick();
    checks++; if (bad != 0) begin fails++; $display("FAIL random_traffic: got %0d mismatches want 0", bad); end
  endtask

  task automatic test_reset_midfill();
    logic [2:0] c, vw, d, exp; logic v;
    int bad;
    c = 3'd6;
    bus.wr_valid = 1; bus.wr_x = 7'd72; bus.wr_y = 7'd1; bus.wr_data = 3'd7;
    tick();
    bus.wr_valid = 0;
    model[200] = 3'd7;
    do_read(72, 1, d, v);
    vw = (model[100] == 3'd1) ? 3'd2 : 3'd1;
    bus.wr_valid = 1; bus.wr_x = 7'd100; bus.wr_y = 7'd0; bus.wr_data = vw;
    bus.fill_start = 1; bus.fill_color = c; #1;
    checks++; if (bus.wr_ready !== 1'b1) begin fails++; $display("FAIL collide_ready_same: got %b want 1", bus.wr_ready); end
    tick();
    bus.fill_start = 0;
    model[100] = vw;
    checks++; if (bus.busy !== 1'b1 || bus.wr_ready !== 1'b0) begin fails++; $display("FAIL collide_fill_wins: got busy %b ready %b want 1 0", bus.busy, bus.wr_ready); end
    bus.wr_valid = 0;
    repeat (100) tick();
    rst = 1; #1;
    checks++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL midfill_busy: got %b want 0", bus.busy); end
    checks++; if (bus.err_oor !== 1'b0) begin fails++; $display("FAIL midfill_err: got %b want 0", bus.err_oor); end
    checks++; if (bus.rd_data !== 3'd0 || bus.rd_valid !== 1'b0) begin fails++; $display("FAIL midfill_rd: got %0d/%b want 0/0", bus.rd_data, bus.rd_valid); end
    tick();
    rst = 0;
    tick();
    checks++; if (bus.wr_ready !== 1'b1) begin fails++; $display("FAIL midfill_ready: got %b want 1", bus.wr_ready); end
    for (int i = 0; i < 100; i++) model[i] = c;
    bad = 0;
    for (int i = 0; i <= 101; i++) begin
      exp = model[i];
      do_read(i % H, i / H, d, v);
      if (d !== exp || v !== 1'b1) bad++;
    end
    do_read(72, 1, d, v);
    if (d !== model[200]) bad++;
    checks++; if (bad != 0) begin fails++; $display("FAIL midfill_contents: got %0d mismatches want 0", bad); end
    checks++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL midfill_stays_idle: got %b want 0", bus.busy); end
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    test_reset();
    test_write_read();
    test_fill();
    test_fill_stall();
    test_oor();
    test_back_to_back();
    test_random();
    test_reset_midfill();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
